// File: rtl/stepper_seq.sv
// Stepper-motor phase sequencer: turns synchronised step_clk rising edges into
// unipolar coil phases and tracks absolute position. Optional macro: COIL_RELEASE_EN.
module stepper_seq #(
    parameter int STEP_W      = 16,
    parameter int POS_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    step_clk_i,
    input  logic                    start_i,
    input  logic                    dir_i,
    input  logic                    half_i,
    input  logic [STEP_W-1:0]       steps_i,
    input  logic                    abort_i,
    output logic [3:0]              coils_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic signed [POS_W-1:0] pos_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                hist_q;
    logic                step_ev_q;
    logic [2:0]          idx_q, idx_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic                dir_q, dir_d;
    logic                half_q, half_d;
    logic [3:0]          coils_q, coils_d;

    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b1000;
            3'd1:    phase = 4'b1100;
            3'd2:    phase = 4'b0100;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0010;
            3'd5:    phase = 4'b0011;
            3'd6:    phase = 4'b0001;
            default: phase = 4'b1001;
        endcase
    endfunction

    // Synchroniser plus registered rising-edge detect; step_ev_q is a one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            step_ev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], step_clk_i};
            hist_q    <= sync_q[SYNC_STAGES-1];
            step_ev_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            pos_q       <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            coils_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            coils_q     <= coils_d;
        end
    end

    // Next-state logic; full step moves two indices so idx parity is preserved.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pos_d       = pos_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        half_d      = half_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dir_d       = dir_i;
                    half_d      = half_i;
                    remaining_d = steps_i;
                    state_d     = (steps_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = DONE;
                end else if (step_ev_q) begin
                    if (dir_q) begin
                        idx_d = idx_q + (half_q ? 3'd1 : 3'd2);
                        pos_d = pos_q + (half_q ? POS_W'(1) : POS_W'(2));
                    end else begin
                        idx_d = idx_q - (half_q ? 3'd1 : 3'd2);
                        pos_d = pos_q - (half_q ? POS_W'(1) : POS_W'(2));
                    end
                    remaining_d = remaining_q - STEP_W'(1);
                    if (remaining_q == STEP_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; coils are registered from next-state so they move with idx.
    always_comb begin
`ifdef COIL_RELEASE_EN
        coils_d = (state_d == RUN) ? phase(idx_d) : 4'b0000;
`else
        coils_d = phase(idx_d);
`endif
        busy_o = (state_q == RUN);
        done_o = (state_q == DONE);
    end

    assign coils_o = coils_q;
    assign pos_o   = $signed(pos_q);

endmodule

// File: tb/tb_stepper_seq.sv
// Scoreboard bench for stepper_seq: expected coils/pos pushed as each step_clk
// pulse is driven, popped and compared when the step lands.
module tb_stepper_seq;
    localparam int S = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               step_clk = 1'b0;
    logic               start = 1'b0;
    logic               dir = 1'b0;
    logic               half = 1'b0;
    logic [15:0]        steps = '0;
    logic               abort = 1'b0;
    logic [3:0]         coils;
    logic               busy;
    logic               done;
    logic signed [31:0] pos;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]         coils;
        logic signed [31:0] pos;
    } exp_t;
    exp_t sb[$];

    int                 m_idx = 0;
    logic signed [31:0] m_pos = 0;
    bit                 m_dir = 0;
    bit                 m_half = 0;

    stepper_seq #(.STEP_W(16), .POS_W(32), .SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_i(rst), .step_clk_i(step_clk), .start_i(start),
        .dir_i(dir), .half_i(half), .steps_i(steps), .abort_i(abort),
        .coils_o(coils), .busy_o(busy), .done_o(done), .pos_o(pos)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] tbl(input int i);
        case (i)
            0: return 4'b1000; 1: return 4'b1100; 2: return 4'b0100; 3: return 4'b0110;
            4: return 4'b0010; 5: return 4'b0011; 6: return 4'b0001; default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [3:0] idle_coils();
`ifdef COIL_RELEASE_EN
        return 4'b0000;
`else
        return tbl(m_idx);
`endif
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_idx = 0;
        m_pos = 0;
        sb.delete();
    endtask

    // mode: 0 mid-move step, 1 final step, 2 abort on the step_ev cycle, 3 no move active
    task automatic do_step(input int mode, input string name);
        exp_t e;
        exp_t got;
        int   d;
        if (mode == 0 || mode == 1) begin
            d = m_half ? 1 : 2;
            m_idx = m_dir ? (m_idx + d) % 8 : (m_idx + 8 - d) % 8;
            m_pos = m_dir ? m_pos + d : m_pos - d;
        end
        e.pos   = m_pos;
        e.coils = (mode == 0) ? tbl(m_idx) : idle_coils();
        sb.push_back(e);
        step_clk = 1'b1;
        repeat (S + 1) @(posedge clk);
        #1;
        if (mode == 2) abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            n_checks++;
            if (coils !== got.coils) begin
                n_fail++;
                $display("FAIL %s coils got=%b exp=%b", name, coils, got.coils);
            end
            n_checks++;
            if (pos !== got.pos) begin
                n_fail++;
                $display("FAIL %s pos got=%0d exp=%0d", name, pos, got.pos);
            end
        end
        n_checks++;
        if (mode == 1 || mode == 2) begin
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s end done=%b busy=%b exp done=1 busy=0", name, done, busy);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after done=%b busy=%b exp 0 0", name, done, busy);
            end
        end else if (mode == 0) begin
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy=%b done=%b exp busy=1 done=0", name, busy, done);
            end
        end else begin
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle busy=%b done=%b exp 0 0", name, busy, done);
            end
        end
        step_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic start_move(input bit d, input bit h, input int n);
        dir = d; half = h; steps = 16'(n); start = 1'b1;
        m_dir = d; m_half = h;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (coils !== 4'b0000 || pos !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset coils=%b pos=%0d busy=%b done=%b exp 0000 0 0 0", coils, pos, busy, done);
        end
        rst = 1'b0;
        m_idx = 0; m_pos = 0;
        @(posedge clk); #1;
        n_checks++;
        if (coils !== idle_coils()) begin
            n_fail++;
            $display("FAIL reset_release coils got=%b exp=%b", coils, idle_coils());
        end
    endtask

    task automatic test_full_fwd();
        apply_reset();
        start_move(1'b1, 1'b0, 4);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_start busy=%b done=%b exp 1 0", busy, done);
        end
        do_step(0, "full1"); do_step(0, "full2"); do_step(0, "full3"); do_step(1, "full4");
        n_checks++;
        if (pos !== 32'sd8) begin
            n_fail++;
            $display("FAIL full_pos got=%0d exp=8", pos);
        end
    endtask

    task automatic test_half_rev();
        apply_reset();
        start_move(1'b0, 1'b1, 3);
        do_step(0, "half1"); do_step(0, "half2"); do_step(1, "half3");
        n_checks++;
        if (pos !== -32'sd3 || m_idx != 5) begin
            n_fail++;
            $display("FAIL half_end pos got=%0d exp=-3", pos);
        end
    endtask

    task automatic test_zero_len();
        logic [3:0]         c0;
        logic signed [31:0] p0;
        c0 = idle_coils(); p0 = m_pos;
        start_move(1'b1, 1'b1, 0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done done=%b busy=%b exp 1 0", done, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || coils !== c0 || pos !== p0) begin
            n_fail++;
            $display("FAIL zero_after done=%b busy=%b coils=%b pos=%0d exp 0 0 %b %0d",
                     done, busy, coils, pos, c0, p0);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        start_move(1'b1, 1'b1, 10);
        do_step(0, "abort_s1"); do_step(0, "abort_s2"); do_step(2, "abort_s3");
        n_checks++;
        if (pos !== 32'sd2 || m_idx != 2) begin
            n_fail++;
            $display("FAIL abort_pos got=%0d exp=2", pos);
        end
    endtask

    task automatic test_ignore_and_rst();
        apply_reset();
        do_step(3, "idle_toggle1");
        do_step(3, "idle_toggle2");
        // start while busy must not change the 2-step length
        start_move(1'b1, 1'b0, 2);
        do_step(0, "busy_s1");
        dir = 1'b0; half = 1'b1; steps = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        do_step(1, "busy_s2");
        // reset mid-move
        start_move(1'b1, 1'b1, 5);
        do_step(0, "rst_s1");
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (coils !== 4'b0000 || pos !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid coils=%b pos=%0d busy=%b done=%b exp 0000 0 0 0", coils, pos, busy, done);
        end
        rst = 1'b0;
        m_idx = 0; m_pos = 0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        start_move(1'b1, 1'b0, 1);
        do_step(1, "b2b_a");
        start_move(1'b0, 1'b1, 1);
        do_step(1, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_full_fwd();
        test_half_rev();
        test_zero_len();
        test_abort();
        test_ignore_and_rst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
